// File: rtl/cache_types_pkg.sv
// Shared types for the data cache: address layout, frame contents and the
// controller state encoding.
//   DC_SETS / DC_IDX_W / DC_TAG_W : default cache geometry (16 frames)
//   DC_TAG_MAX                     : stored tag width, wide enough for any SETS >= 2
//   dc_addr_t                      : byte address split at the default geometry
//   dc_frame_t                     : one cache frame (valid, dirty, tag, 2 words)
//   dc_state_e                     : controller states
package cache_types_pkg;

  localparam int unsigned DC_SETS      = 16;
  localparam int unsigned DC_IDX_W     = $clog2(DC_SETS);
  localparam int unsigned DC_TAG_W     = 29 - DC_IDX_W;
  localparam int unsigned DC_BLK_WORDS = 2;
  localparam int unsigned DC_TAG_MAX   = 28;

  typedef struct packed {
    logic [DC_TAG_W-1:0] tag;
    logic [DC_IDX_W-1:0] idx;
    logic                blkoff;
    logic [1:0]          bytoff;
  } dc_addr_t;

  typedef struct packed {
    logic                              valid;
    logic                              dirty;
    logic [DC_TAG_MAX-1:0]             tag;
    logic [DC_BLK_WORDS-1:0][31:0]     word;
  } dc_frame_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FLUSH_SCAN,
    FL0,
    FL1,
    DONE
  } dc_state_e;

endpackage

// File: rtl/dcache_frame_array.sv
// Frame storage for the direct-mapped data cache.
//   CLK, nRST    : clock, asynchronous active-low clear of every frame
//   idx          : frame index shared by the read and write ports
//   rd_frame     : contents of frame idx
//   wr_word_en   : write wr_data into word wr_off of frame idx
//   wr_dirty_en  : load wr_dirty into the dirty bit of frame idx
//   wr_fill_en   : set valid and load wr_tag into frame idx
module dcache_frame_array
  import cache_types_pkg::*;
#(
  parameter int unsigned SETS = DC_SETS
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [$clog2(SETS)-1:0] idx,
  output dc_frame_t               rd_frame,
  input  logic                    wr_word_en,
  input  logic                    wr_off,
  input  logic [31:0]             wr_data,
  input  logic                    wr_dirty_en,
  input  logic                    wr_dirty,
  input  logic                    wr_fill_en,
  input  logic [DC_TAG_MAX-1:0]   wr_tag
);

  dc_frame_t frames [SETS];

  assign rd_frame = frames[idx];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        frames[i] <= '0;
      end
    end else begin
      if (wr_word_en) begin
        frames[idx].word[wr_off] <= wr_data;
      end
      if (wr_dirty_en) begin
        frames[idx].dirty <= wr_dirty;
      end
      if (wr_fill_en) begin
        frames[idx].valid <= 1'b1;
        frames[idx].tag   <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with halt-time flush.
//   CLK, nRST                 : clock, asynchronous active-low reset
//   dmemREN/WEN/addr/store    : datapath request (held until dhit)
//   halt                      : start writing every dirty block back
//   dhit, dmemload            : request serviced this cycle, load data
//   flushed                   : flush complete, held until reset
//   dREN/dWEN/daddr/dstore    : memory-side word transfer request
//   dwait, dload              : memory busy flag, memory read data
module dcache_responder
  import cache_types_pkg::*;
#(
  parameter int unsigned SETS = DC_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 29 - IDX_W;

  dc_state_e        state, state_next;
  logic [IDX_W-1:0] scan_idx, scan_idx_next;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_off;
  logic             req;
  logic             unused_bytoff;

  assign req_tag       = dmemaddr[31:3+IDX_W];
  assign req_idx       = dmemaddr[2+IDX_W:3];
  assign req_off       = dmemaddr[2];
  assign req           = dmemREN | dmemWEN;
  assign unused_bytoff = ^dmemaddr[1:0];

  logic             flushing;
  logic [IDX_W-1:0] frame_idx;
  dc_frame_t        frame;
  logic [TAG_W-1:0] frame_tag;
  logic             tag_match;
  logic             last_idx;

  // The flush walks its own index; everything else looks at the request's frame.
  assign flushing  = (state == FLUSH_SCAN) || (state == FL0) || (state == FL1);
  assign frame_idx = flushing ? scan_idx : req_idx;
  assign frame_tag = frame.tag[TAG_W-1:0];
  assign tag_match = frame.valid && (frame.tag == DC_TAG_MAX'(req_tag));
  assign last_idx  = (scan_idx == IDX_W'(SETS - 1));

  logic        wr_word_en;
  logic        wr_off;
  logic [31:0] wr_data;
  logic        wr_dirty_en;
  logic        wr_dirty;
  logic        wr_fill_en;

  dcache_frame_array #(
    .SETS(SETS)
  ) u_frames (
    .CLK        (CLK),
    .nRST       (nRST),
    .idx        (frame_idx),
    .rd_frame   (frame),
    .wr_word_en (wr_word_en),
    .wr_off     (wr_off),
    .wr_data    (wr_data),
    .wr_dirty_en(wr_dirty_en),
    .wr_dirty   (wr_dirty),
    .wr_fill_en (wr_fill_en),
    .wr_tag     (DC_TAG_MAX'(req_tag))
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      scan_idx <= '0;
    end else begin
      state    <= state_next;
      scan_idx <= scan_idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    scan_idx_next = scan_idx;
    dhit          = 1'b0;
    dmemload      = '0;
    flushed       = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    daddr         = '0;
    dstore        = '0;
    wr_word_en    = 1'b0;
    wr_off        = 1'b0;
    wr_data       = '0;
    wr_dirty_en   = 1'b0;
    wr_dirty      = 1'b0;
    wr_fill_en    = 1'b0;

    unique case (state)
      IDLE: begin
        // halt wins over a request presented in the same cycle
        if (halt) begin
          state_next    = FLUSH_SCAN;
          scan_idx_next = '0;
        end else if (req) begin
          if (tag_match) begin
            dhit     = 1'b1;
            dmemload = frame.word[req_off];
            if (dmemWEN) begin
              wr_word_en  = 1'b1;
              wr_off      = req_off;
              wr_data     = dmemstore;
              wr_dirty_en = 1'b1;
              wr_dirty    = 1'b1;
            end
          end else begin
            state_next = (frame.valid && frame.dirty) ? WB0 : LD0;
          end
        end
      end

      WB0: begin
        dWEN   = 1'b1;
        daddr  = {frame_tag, req_idx, 1'b0, 2'b00};
        dstore = frame.word[0];
        if (!dwait) state_next = WB1;
      end

      WB1: begin
        dWEN   = 1'b1;
        daddr  = {frame_tag, req_idx, 1'b1, 2'b00};
        dstore = frame.word[1];
        if (!dwait) begin
          wr_dirty_en = 1'b1;
          state_next  = LD0;
        end
      end

      LD0: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b0, 2'b00};
        if (!dwait) begin
          wr_word_en = 1'b1;
          wr_data    = dload;
          state_next = LD1;
        end
      end

      LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 1'b1, 2'b00};
        if (!dwait) begin
          wr_word_en  = 1'b1;
          wr_off      = 1'b1;
          wr_data     = dload;
          wr_dirty_en = 1'b1;
          wr_fill_en  = 1'b1;
          state_next  = IDLE;
        end
      end

      FLUSH_SCAN: begin
        if (frame.valid && frame.dirty) begin
          state_next = FL0;
        end else if (last_idx) begin
          state_next = DONE;
        end else begin
          scan_idx_next = scan_idx + 1'b1;
        end
      end

      FL0: begin
        dWEN   = 1'b1;
        daddr  = {frame_tag, scan_idx, 1'b0, 2'b00};
        dstore = frame.word[0];
        if (!dwait) state_next = FL1;
      end

      FL1: begin
        dWEN   = 1'b1;
        daddr  = {frame_tag, scan_idx, 1'b1, 2'b00};
        dstore = frame.word[1];
        if (!dwait) begin
          wr_dirty_en = 1'b1;
          if (last_idx) begin
            state_next = DONE;
          end else begin
            scan_idx_next = scan_idx + 1'b1;
            state_next    = FLUSH_SCAN;
          end
        end
      end

      DONE: begin
        flushed = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
